// File: rtl/audio_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : audio_frame_sequencer
// Description : Packs a 16-bit sample stream into 512-bit words for one
//               2048-sample AudioProcessor frame, starts the core, waits for
//               done and unloads the processed frame as a sample stream.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_frame_sequencer #(
  parameter  int SAMPLE_W = 16,
  parameter  int LANES    = 32,
  parameter  int WORDS    = 64,
  localparam int IDX_W    = $clog2(WORDS),
  localparam int BUS_W    = SAMPLE_W * LANES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                in_ready,
  output logic                data_wr_en,
  output logic [IDX_W-1:0]    input_index,
  output logic [BUS_W-1:0]    data_in,
  output logic                start,
  input  logic                done,
  output logic [IDX_W-1:0]    output_index,
  input  logic [BUS_W-1:0]    data_out,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_data,
  input  logic                out_ready,
  output logic                busy,
  output logic [15:0]         frame_count
);

  localparam int LANE_W = $clog2(LANES);
  localparam int OFS_W  = $clog2(BUS_W);
  localparam logic [LANE_W-1:0] c_LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [IDX_W-1:0]  c_LAST_WORD = IDX_W'(WORDS - 1);

  typedef enum logic [2:0] {
    S_FILL      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_RD_ADDR   = 3'd3,
    S_RD_CAP    = 3'd4,
    S_EMIT      = 3'd5
  } state_t;

  state_t              r_state;
  logic [LANE_W-1:0]   r_lane_cnt;
  logic [IDX_W-1:0]    r_word_cnt;
  logic                r_done_q;
  logic [BUS_W-1:0]    r_pack;
  logic [BUS_W-1:0]    r_unpack;

  logic                w_accept;
  logic                w_emit_ack;
  logic                w_done_rise;
  logic                w_last_lane;
  logic                w_last_word;
  logic [LANE_W-1:0]   w_lane_next;
  logic [OFS_W-1:0]    w_wr_ofs;
  logic [OFS_W-1:0]    w_rd_ofs;

  assign w_accept    = in_valid & in_ready;
  assign w_emit_ack  = out_valid & out_ready;
  assign w_done_rise = done & ~r_done_q;
  assign w_last_lane = (r_lane_cnt == c_LAST_LANE);
  assign w_last_word = (r_word_cnt == c_LAST_WORD);
  assign w_lane_next = r_lane_cnt + 1'b1;
  assign w_wr_ofs    = OFS_W'(r_lane_cnt)  * OFS_W'(SAMPLE_W);
  assign w_rd_ofs    = OFS_W'(w_lane_next) * OFS_W'(SAMPLE_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FILL;
      r_lane_cnt   <= '0;
      r_word_cnt   <= '0;
      r_done_q     <= 1'b0;
      r_pack       <= '0;
      r_unpack     <= '0;
      in_ready     <= 1'b1;
      data_wr_en   <= 1'b0;
      input_index  <= '0;
      data_in      <= '0;
      start        <= 1'b0;
      output_index <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      busy         <= 1'b0;
      frame_count  <= '0;
    end else begin
      r_done_q   <= done;
      data_wr_en <= 1'b0;
      start      <= 1'b0;

      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            r_pack[w_wr_ofs +: SAMPLE_W] <= in_data;
            r_lane_cnt                   <= w_lane_next;
            // Last lane bypasses the pack register so the next word can start immediately.
            if (w_last_lane) begin
              data_in     <= {in_data, r_pack[BUS_W-SAMPLE_W-1:0]};
              data_wr_en  <= 1'b1;
              input_index <= r_word_cnt;
              r_word_cnt  <= r_word_cnt + 1'b1;
              if (w_last_word) begin
                in_ready <= 1'b0;
                busy     <= 1'b1;
                r_state  <= S_START;
              end
            end
          end
        end

        S_START: begin
          start   <= 1'b1;
          r_state <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          if (w_done_rise) begin
            r_word_cnt   <= '0;
            output_index <= '0;
            r_state      <= S_RD_ADDR;
          end
        end

        // output_index is held here; the core presents data_out one cycle later.
        S_RD_ADDR: begin
          r_state <= S_RD_CAP;
        end

        S_RD_CAP: begin
          r_unpack   <= data_out;
          r_lane_cnt <= '0;
          out_data   <= data_out[SAMPLE_W-1:0];
          out_valid  <= 1'b1;
          r_state    <= S_EMIT;
        end

        S_EMIT: begin
          if (w_emit_ack) begin
            r_lane_cnt <= w_lane_next;
            if (!w_last_lane) begin
              out_data <= r_unpack[w_rd_ofs +: SAMPLE_W];
            end else begin
              out_valid <= 1'b0;
              if (!w_last_word) begin
                r_word_cnt   <= r_word_cnt + 1'b1;
                output_index <= r_word_cnt + 1'b1;
                r_state      <= S_RD_ADDR;
              end else begin
                frame_count <= frame_count + 1'b1;
                r_word_cnt  <= '0;
                r_lane_cnt  <= '0;
                in_ready    <= 1'b1;
                busy        <= 1'b0;
                r_state     <= S_FILL;
              end
            end
          end
        end

        default: begin
          r_lane_cnt <= '0;
          r_word_cnt <= '0;
          in_ready   <= 1'b1;
          out_valid  <= 1'b0;
          busy       <= 1'b0;
          r_state    <= S_FILL;
        end
      endcase
    end
  end

  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(in_ready && out_valid));

  a_start_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    start |=> !start);

endmodule
`default_nettype wire

// File: tb/tb_audio_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_frame_sequencer
// Description : Directed self-checking bench for audio_frame_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_frame_sequencer;

  localparam int c_SAMPLES = 2048;
  localparam int c_LANES   = 32;
  localparam int c_WORDS   = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [15:0]  in_data = '0;
  logic         in_ready;
  logic         data_wr_en;
  logic [5:0]   input_index;
  logic [511:0] data_in;
  logic         start;
  logic         done = 1'b0;
  logic [5:0]   output_index;
  logic [511:0] data_out = '0;
  logic         out_valid;
  logic [15:0]  out_data;
  logic         out_ready = 1'b1;
  logic         busy;
  logic [15:0]  frame_count;

  int n_checks = 0;
  int n_fail   = 0;

  audio_frame_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .data_wr_en   (data_wr_en),
    .input_index  (input_index),
    .data_in      (data_in),
    .start        (start),
    .done         (done),
    .output_index (output_index),
    .data_out     (data_out),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .busy         (busy),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  // Core model: registered read, each lane returns the input ramp value plus one.
  always @(posedge clk) begin
    for (int k = 0; k < c_LANES; k++)
      data_out[16*k +: 16] <= 16'(32 * int'(output_index) + k + 1);
  end

  // Transaction monitor
  logic         mon_clr = 1'b0;
  int           cyc = 0;
  int           wr_cnt = 0;
  int           acc_cnt = 0;
  int           start_cnt = 0;
  int           out_cnt = 0;
  int           overlap = 0;
  logic [511:0] cap_word [c_WORDS];
  int           cap_idx  [c_WORDS];
  int           acc_at_wr[c_WORDS];
  int           wr_cyc   [c_WORDS];
  logic [15:0]  out_log  [c_SAMPLES];
  int           out_cyc  [c_SAMPLES];

  always @(posedge clk) begin
    cyc++;
    if (mon_clr) begin
      wr_cnt = 0; acc_cnt = 0; start_cnt = 0; out_cnt = 0;
    end else begin
      if (data_wr_en) begin
        if (wr_cnt < c_WORDS) begin
          cap_word[wr_cnt]  = data_in;
          cap_idx[wr_cnt]   = int'(input_index);
          acc_at_wr[wr_cnt] = acc_cnt;
          wr_cyc[wr_cnt]    = cyc;
        end
        wr_cnt++;
      end
      if (in_valid && in_ready) acc_cnt++;
      if (start) start_cnt++;
      if (out_valid && out_ready) begin
        if (out_cnt < c_SAMPLES) begin
          out_log[out_cnt] = out_data;
          out_cyc[out_cnt] = cyc;
        end
        out_cnt++;
      end
    end
    if (in_ready && out_valid) overlap++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_monitor();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic feed(input int count, input bit rnd, input logic [15:0] base, output int got);
    int n = 0;
    int g = 0;
    while (n < count && g < 20000) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = base + 16'(n);
      if (in_valid && in_ready) n++;
      tick();
      g++;
    end
    in_valid = 1'b0;
    got = n;
  endtask

  // Errors in captured words against the ramp: word w lane k = 32w+k.
  function automatic int ramp_word_errs();
    int e = 0;
    for (int w = 0; w < c_WORDS; w++) begin
      if (cap_idx[w] != w) e++;
      for (int k = 0; k < c_LANES; k++)
        if (cap_word[w][16*k +: 16] !== 16'(32 * w + k)) e++;
    end
    return e;
  endfunction

  function automatic int out_seq_errs();
    int e = 0;
    for (int i = 0; i < c_SAMPLES; i++)
      if (out_log[i] !== 16'(i + 1)) e++;
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (data_wr_en !== 1'b0 || start !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_strobes: got wr=%b start=%b ov=%b busy=%b expected all 0", data_wr_en, start, out_valid, busy); end
    n_checks++; if (input_index !== 6'd0 || output_index !== 6'd0 || data_in !== '0 || out_data !== 16'd0 || frame_count !== 16'd0) begin
      n_fail++; $display("FAIL rst_values: got ii=%0d oi=%0d out=%0d fc=%0d expected 0", input_index, output_index, out_data, frame_count); end
  endtask

  task automatic test_mid_fill_reset();
    int got;
    feed(100, 1'b0, 16'h8000, got);
    n_checks++; if (wr_cnt !== 3) begin n_fail++; $display("FAIL pre_reset_writes: got %0d expected 3", wr_cnt); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL async_rst_ready: got in_ready=%b busy=%b expected 1/0", in_ready, busy); end
    n_checks++; if (data_in !== '0 || input_index !== 6'd0 || data_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL async_rst_wr: got ii=%0d wr=%b expected 0/0 with data_in cleared", input_index, data_wr_en); end
    n_checks++; if (start !== 1'b0 || out_valid !== 1'b0 || frame_count !== 16'd0) begin
      n_fail++; $display("FAIL async_rst_misc: got start=%b ov=%b fc=%0d expected 0", start, out_valid, frame_count); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_monitor();
  endtask

  task automatic test_ramp_fill();
    int got;
    int e;
    done = 1'b1;  // held high through fill so the WAIT_DONE entry sees a level, not an edge
    feed(c_SAMPLES, 1'b0, 16'd0, got);
    n_checks++; if (got !== c_SAMPLES) begin n_fail++; $display("FAIL fill_timeout: got %0d accepts expected %0d", got, c_SAMPLES); end
    n_checks++; if (data_wr_en !== 1'b1 || input_index !== 6'd63) begin
      n_fail++; $display("FAIL last_write: got wr=%b idx=%0d expected 1/63", data_wr_en, input_index); end
    n_checks++; if (in_ready !== 1'b0 || start !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL after_fill: got in_ready=%b start=%b busy=%b expected 0/0/1", in_ready, start, busy); end
    tick();
    n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL start_pulse: got %b expected 1", start); end
    tick();
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL start_width: got %b expected 0", start); end
    n_checks++; if (wr_cnt !== c_WORDS) begin n_fail++; $display("FAIL write_count: got %0d expected %0d", wr_cnt, c_WORDS); end
    e = ramp_word_errs();
    n_checks++; if (e !== 0) begin n_fail++; $display("FAIL ramp_words: got %0d bad lanes/indices expected 0", e); end
    n_checks++; if (cap_word[0][15:0] !== 16'd0) begin
      n_fail++; $display("FAIL first_sample: got %0h expected 0", cap_word[0][15:0]); end
    e = 0;
    for (int w = 0; w < c_WORDS; w++) begin
      if (acc_at_wr[w] != 32 * (w + 1)) e++;
      if (w > 0 && wr_cyc[w] - wr_cyc[w-1] != 32) e++;
    end
    n_checks++; if (e !== 0) begin n_fail++; $display("FAIL write_timing: got %0d errors expected 0", e); end
  endtask

  task automatic test_done_edge();
    int early = 0;
    repeat (20) begin tick(); if (out_valid !== 1'b0) early++; end
    done = 1'b0;
    repeat (500) begin tick(); if (out_valid !== 1'b0) early++; end
    n_checks++; if (early !== 0) begin n_fail++; $display("FAIL done_level_ignored: got %0d early out_valid cycles expected 0", early); end
    done = 1'b1;
    tick();
    n_checks++; if (output_index !== 6'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rd_addr: got oi=%0d ov=%b expected 0/0", output_index, out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rd_cap: got ov=%b expected 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'd1) begin
      n_fail++; $display("FAIL first_out: got ov=%b data=%0d expected 1/1", out_valid, out_data); end
  endtask

  task automatic test_drain();
    int g = 0;
    int e = 0;
    while (out_cnt < c_SAMPLES && g < 5000) begin tick(); g++; end
    done = 1'b0;
    n_checks++; if (out_cnt !== c_SAMPLES) begin n_fail++; $display("FAIL drain_count: got %0d expected %0d", out_cnt, c_SAMPLES); end
    e = out_seq_errs();
    n_checks++; if (e !== 0) begin n_fail++; $display("FAIL drain_seq: got %0d wrong samples expected 0", e); end
    e = 0;
    for (int i = 1; i < c_SAMPLES; i++)
      if (out_cyc[i] - out_cyc[i-1] != ((i % 32 == 0) ? 3 : 1)) e++;
    n_checks++; if (e !== 0) begin n_fail++; $display("FAIL drain_gaps: got %0d bad gaps expected 0", e); end
    n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL frame_count1: got %0d expected 1", frame_count); end
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL back_to_fill: got in_ready=%b busy=%b ov=%b expected 1/0/0", in_ready, busy, out_valid); end
    n_checks++; if (start_cnt !== 1) begin n_fail++; $display("FAIL start_count: got %0d expected 1", start_cnt); end
  endtask

  task automatic test_back_to_back();
    int got;
    int e;
    int g = 0;
    int stall_err = 0;
    bit stalled = 1'b0;
    clear_monitor();
    feed(c_SAMPLES, 1'b1, 16'd0, got);
    n_checks++; if (got !== c_SAMPLES) begin n_fail++; $display("FAIL rnd_fill_timeout: got %0d expected %0d", got, c_SAMPLES); end
    e = ramp_word_errs();
    for (int w = 0; w < c_WORDS; w++)
      if (acc_at_wr[w] != 32 * (w + 1)) e++;
    n_checks++; if (e !== 0) begin n_fail++; $display("FAIL rnd_words: got %0d errors expected 0", e); end
    while (start_cnt == 0 && g < 100) begin tick(); g++; end
    n_checks++; if (start_cnt !== 1) begin n_fail++; $display("FAIL rnd_start: got %0d expected 1", start_cnt); end
    repeat (5) tick();
    done = 1'b1;
    g = 0;
    while (out_cnt < c_SAMPLES && g < 6000) begin
      if (!stalled && out_valid && out_data == 16'd240) begin
        out_ready = 1'b0;
        repeat (10) begin
          tick();
          if (out_valid !== 1'b1 || out_data !== 16'd240) stall_err++;
        end
        out_ready = 1'b1;
        stalled = 1'b1;
      end
      tick();
      g++;
    end
    repeat (5) tick();
    n_checks++; if (stalled !== 1'b1 || stall_err !== 0) begin
      n_fail++; $display("FAIL stall_hold: got stalled=%b errors=%0d expected 1/0", stalled, stall_err); end
    n_checks++; if (out_cnt !== c_SAMPLES) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", out_cnt, c_SAMPLES); end
    e = out_seq_errs();
    n_checks++; if (e !== 0) begin n_fail++; $display("FAIL b2b_seq: got %0d wrong samples expected 0", e); end
    n_checks++; if (frame_count !== 16'd2) begin n_fail++; $display("FAIL frame_count2: got %0d expected 2", frame_count); end
    n_checks++; if (overlap !== 0) begin n_fail++; $display("FAIL ready_valid_overlap: got %0d expected 0", overlap); end
  endtask

  initial begin
    test_reset();
    test_mid_fill_reset();
    test_ramp_fill();
    test_done_edge();
    test_drain();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
